// File: rtl/config_loader.sv
// Assembles a word-serial bitstream into the core's config vector and holds the core in reset until it is complete (optional checksum: CONFIG_LOADER_CHECKSUM_EN).
// Latency: each word appears on config_out one cycle after its transfer; done/core_nreset rise the cycle after the final transfer.
// Backpressure: word_ready is high only while loading (or awaiting the checksum); gaps in word_valid simply stall the load.
module config_loader #(
    parameter int CONFIG_WIDTH = 1602,
    parameter int WORD_WIDTH   = 32
) (
    input  logic                    clock,
    input  logic                    nreset,
    input  logic                    start,
    input  logic [WORD_WIDTH-1:0]   word_in,
    input  logic                    word_valid,
    output logic                    word_ready,
    output logic [CONFIG_WIDTH-1:0] config_out,
    output logic                    core_nreset,
    output logic                    busy,
    output logic                    done,
    output logic                    error
);

    localparam int NWORDS  = (CONFIG_WIDTH + WORD_WIDTH - 1) / WORD_WIDTH;
    localparam int CNT_W   = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam int LAST_LO = (NWORDS - 1) * WORD_WIDTH;
    localparam int LAST_W  = CONFIG_WIDTH - LAST_LO;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NWORDS - 1);

`ifdef CONFIG_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DONE, S_CHECK, S_ERROR} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;
`endif

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  count_q;
    logic              enter_load;
    logic              clear_cfg;
    logic              xfer;
    logic              load_xfer;

    assign xfer      = word_valid & word_ready;
    assign load_xfer = xfer && (state_q == S_LOAD);

`ifdef CONFIG_LOADER_CHECKSUM_EN
    logic [WORD_WIDTH-1:0] sum_q;
    logic [WORD_WIDTH-1:0] sum_chk;
    assign sum_chk = sum_q + word_in;
`endif

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        enter_load = 1'b0;
        clear_cfg  = 1'b0;
        case (state_q)
            S_LOAD: begin
                if (xfer && count_q == LAST_IDX) begin
`ifdef CONFIG_LOADER_CHECKSUM_EN
                    state_d = S_CHECK;
`else
                    state_d = S_DONE;
`endif
                end
            end
`ifdef CONFIG_LOADER_CHECKSUM_EN
            S_CHECK: begin
                if (xfer) begin
                    if (sum_chk == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d   = S_ERROR;
                        clear_cfg = 1'b1;
                    end
                end
            end
`endif
            default: begin
                // IDLE, DONE and ERROR all restart a load on start
                if (start) begin
                    state_d    = S_LOAD;
                    enter_load = 1'b1;
                    clear_cfg  = 1'b1;
                end
            end
        endcase
    end

    // Status outputs are registered images of the next state
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            word_ready  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            core_nreset <= 1'b0;
        end else begin
`ifdef CONFIG_LOADER_CHECKSUM_EN
            word_ready  <= (state_d == S_LOAD) || (state_d == S_CHECK);
            busy        <= (state_d == S_LOAD) || (state_d == S_CHECK);
`else
            word_ready  <= (state_d == S_LOAD);
            busy        <= (state_d == S_LOAD);
`endif
            done        <= (state_d == S_DONE);
            core_nreset <= (state_d == S_DONE);
        end
    end

`ifdef CONFIG_LOADER_CHECKSUM_EN
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            error <= 1'b0;
            sum_q <= '0;
        end else begin
            error <= (state_d == S_ERROR);
            if (enter_load)     sum_q <= '0;
            else if (load_xfer) sum_q <= sum_chk;
        end
    end
`else
    assign error = 1'b0;
`endif

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            count_q <= '0;
        end else if (enter_load) begin
            count_q <= '0;
        end else if (load_xfer) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    // The last word is written separately because its top bits fall off the vector
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            config_out <= '0;
        end else if (clear_cfg) begin
            config_out <= '0;
        end else if (load_xfer) begin
            for (int w = 0; w < NWORDS - 1; w++) begin
                if (count_q == CNT_W'(w)) config_out[w*WORD_WIDTH +: WORD_WIDTH] <= word_in;
            end
            if (count_q == LAST_IDX) config_out[CONFIG_WIDTH-1:LAST_LO] <= word_in[LAST_W-1:0];
        end
    end

endmodule

// File: doc/config_loader.md
Name: config_loader

Overview:
- Produces the wide parallel configuration vector that the kFPGA core consumes on its config_in bus.
- Accepts the bitstream as a stream of fixed-width words over a valid/ready handshake and assembles them into a registered configuration vector.
- Holds the core in reset until a complete bitstream has been loaded.
- Sits between the external programming interface and the core's config_in and nreset inputs.

Parameters:
- CONFIG_WIDTH, 1602: width of config_out. Must match the core's config_in width.
- WORD_WIDTH, 32: width of one bitstream word.
- NWORDS, ceil(CONFIG_WIDTH/WORD_WIDTH) = 51 by default: number of data words in one bitstream. Derived localparam.

Ports:
- clock  input  1  single clock, rising edge
- nreset  input  1  reset, asynchronous, active-low
- start  input  1  one-cycle request to begin a new load
- word_in  input  WORD_WIDTH  bitstream word
- word_valid  input  1  word_in is valid
- word_ready  output  1  loader accepts a word this cycle
- config_out  output  CONFIG_WIDTH  registered configuration vector, drives the core's config_in
- core_nreset  output  1  registered active-low reset to the core
- busy  output  1  a load is in progress
- done  output  1  config_out holds a complete, accepted bitstream
- error  output  1  bitstream rejected; tied 0 when the optional feature is absent

Behaviour:
- Reset (nreset=0, asynchronous): state=IDLE, word count=0. All outputs are 0: config_out, core_nreset, busy, done, error, word_ready.
- Transfer: occurs on a rising edge where word_valid=1 and word_ready=1. word_ready is a registered function of state and does not depend on word_valid.
- IDLE:
  - word_ready=0.
  - start=1 moves to LOAD next cycle.
- Entering LOAD from any state, in the same edge as start is sampled:
  - word count=0
  - config_out cleared to 0
  - done=0, error=0
  - core_nreset=0
  - busy=1
- LOAD:
  - word_ready=1.
  - Transfer number k (0..NWORDS-1) writes word_in into config_out[WORD_WIDTH*k +: WORD_WIDTH].
  - Bits of the last word above CONFIG_WIDTH-1 are discarded (30 padding bits by default).
  - Word k is visible on config_out one cycle after its transfer.
  - The count increments only on a transfer. Gaps in word_valid simply stall the load.
  - start is ignored while in LOAD.
  - The transfer with count=NWORDS-1 moves to DONE (or to CHECK when the feature is enabled).
- DONE:
  - word_ready=0, busy=0.
  - done=1 and core_nreset=1, both asserted on the cycle after the final transfer.
  - config_out is held.
  - start=1 begins a reload: core_nreset returns to 0 on the next edge.
- word_valid outside LOAD/CHECK: ignored; no transfer takes place.
- Reset mid-load: asynchronous return to reset values. The partial configuration is lost and the core stays in reset.
- No timeout: the loader waits indefinitely for words.

Optional Feature:
- Macro: CONFIG_LOADER_CHECKSUM_EN.
- Defined:
  - A running sum (mod 2^WORD_WIDTH) accumulates every transferred data word, padding bits included. It is cleared on entry to LOAD.
  - After the last data word the loader enters CHECK with word_ready=1 and accepts exactly one checksum word.
  - If sum + checksum ≡ 0 (mod 2^WORD_WIDTH), move to DONE as above.
  - Otherwise move to ERROR:
    - error=1, done=0
    - core_nreset held 0
    - config_out cleared to 0
    - word_ready=0, busy=0
  - start in ERROR begins a new load.
  - busy=1 in CHECK.
- Undefined: no CHECK or ERROR states, no accumulator, error tied 0.

Test Plan:
- Reset: hold nreset=0 with random inputs -> all outputs 0. Release -> IDLE, word_ready=0.
- Full load: start, then 51 back-to-back words with word k = k+1 -> the following hold, one cycle after transfer 51:
  - config_out[31:0]=1
  - config_out[63:32]=2
  - config_out[1601:1600]=2'b11
  - done=1, core_nreset=1, busy=0
- Stalls and spurious start: word_valid toggled every other cycle, plus a start pulse after word 10 -> exactly 51 transfers, same final config_out as the full-load test.
- Reset mid-load: nreset pulsed low after 20 words -> all outputs 0 immediately. A fresh full load afterwards completes correctly.
- Reload from DONE: start -> on the next edge core_nreset=0, done=0, config_out=0, busy=1.
- Checksum (CONFIG_LOADER_CHECKSUM_EN defined): words 1..51 followed by 0xFFFFFAD2 -> done=1. The same sequence followed by 0xFFFFFAD3 -> error=1, core_nreset=0, config_out=0. A subsequent start clears error.
